// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter: default widths, grant encoding
// and the buffered register-write request.
package wb_arb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_REG_W  = 3;

  typedef enum logic [2:0] {
    GNT_NONE  = 3'd0,
    GNT_PIPE  = 3'd1,
    GNT_BUF   = 3'd2,
    GNT_FORCE = 3'd3,
    GNT_BYP   = 3'd4
  } grant_e;

  typedef struct packed {
    logic [WB_REG_W-1:0]  idx;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// In-order buffer of late load returns waiting for the register-file port,
// with a combinational "destination already pending" lookup.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  wb_req_t             push_req,
  input  logic                pop,
  output logic [PW:0]         count,
  output wb_req_t             head,
  input  logic [WB_REG_W-1:0] chk_reg,
  output logic                match
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push && (count_q < (PW+1)'(DEPTH));
  assign do_pop_s  = pop && (count_q != (PW+1)'(0));
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q]   = push_req;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Any live entry targeting the queried register.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match = match | (valid_q[i] && (mem_q[i].idx == chk_reg));
    end
  end

  // State registers; reset drops all buffered contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline write-back
// and buffered load returns, stalling the pipeline only to stop starvation.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_W      = WB_REG_W,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr_en,
  input  logic [REG_W-1:0]  pipe_wr_reg,
  input  logic [DATA_W-1:0] pipe_wr_data,
  output logic              pipe_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_W-1:0]  ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_wr_en,
  output logic [REG_W-1:0]  rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [REG_W-1:0]  chk_reg,
  output logic              chk_pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  grant_e            grant_s;
  logic [CW-1:0]     count_s;
  wb_req_t           head_s, ld_req_s;
  logic              match_s, buf_empty_s, ld_ready_s, push_s, pop_s;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [REG_W-1:0]  rf_wr_reg_q, rf_wr_reg_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;

  assign ld_req_s.idx  = ld_reg;
  assign ld_req_s.data = ld_data;
  assign buf_empty_s   = (count_s == CW'(0));
  // Full-buffer check only: a pop in the same cycle does not open a slot early.
  assign ld_ready_s    = rst_n && (count_s < CW'(DEPTH));
  assign push_s        = ld_valid && ld_ready_s && (grant_s != GNT_BYP);
  assign pop_s         = (grant_s == GNT_FORCE) || (grant_s == GNT_BUF);

  assign ld_ready    = ld_ready_s;
  assign pipe_stall  = rst_n && (grant_s == GNT_FORCE);
  assign chk_pending = rst_n && (match_s || (ld_valid && (ld_reg == chk_reg)));
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_reg   = rf_wr_reg_q;
  assign rf_wr_data  = rf_wr_data_q;

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_req (ld_req_s),
    .pop      (pop_s),
    .count    (count_s),
    .head     (head_s),
    .chk_reg  (chk_reg),
    .match    (match_s)
  );

  // Fixed-priority grant selection.
  always_comb begin
    grant_s = GNT_NONE;
    if (!buf_empty_s && (starve_q == SW'(STARVE_MAX))) begin
      grant_s = GNT_FORCE;
    end else if (pipe_wr_en) begin
      grant_s = GNT_PIPE;
    end else if (!buf_empty_s) begin
      grant_s = GNT_BUF;
    end else if (ld_valid) begin
      grant_s = GNT_BYP;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Write-port mux and starvation tracking.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    starve_d     = starve_q;
    case (grant_s)
      GNT_FORCE, GNT_BUF: begin
        rf_wr_en_d   = 1'b1;
        rf_wr_reg_d  = head_s.idx;
        rf_wr_data_d = head_s.data;
      end
      GNT_PIPE: begin
        rf_wr_en_d   = 1'b1;
        rf_wr_reg_d  = pipe_wr_reg;
        rf_wr_data_d = pipe_wr_data;
      end
      GNT_BYP: begin
        rf_wr_en_d   = 1'b1;
        rf_wr_reg_d  = ld_reg;
        rf_wr_data_d = ld_data;
      end
      default: begin
        rf_wr_en_d = 1'b0;
      end
    endcase
    // The counter only measures pipeline wins while loads are waiting.
    if (buf_empty_s) begin
      starve_d = '0;
    end else begin
      case (grant_s)
        GNT_PIPE: begin
          if (starve_q < SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end
        GNT_BUF, GNT_FORCE: starve_d = '0;
        default:            starve_d = starve_q;
      endcase
    end
  end

  // Registered write port and starve counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
      starve_q     <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model compared every
// cycle, plus hand-computed spot checks along the directed sequence.
module tb_wb_port_arbiter;

  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic          clk, rst_n;
  logic          pipe_wr_en, pipe_stall, ld_valid, ld_ready, rf_wr_en, chk_pending;
  logic [RW-1:0] pipe_wr_reg, ld_reg, rf_wr_reg, chk_reg;
  logic [DW-1:0] pipe_wr_data, ld_data, rf_wr_data;

  wb_port_arbiter #(.DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .pipe_stall(pipe_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .chk_reg(chk_reg), .chk_pending(chk_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  int            m_starve;
  logic          m_en;
  logic [RW-1:0] m_reg;
  logic [DW-1:0] m_data;
  bit            m_ld_taken, m_pipe_taken;
  int            n_vec, n_err;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_ready();
    return rst_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_force();
    return rst_n && (mq.size() > 0) && (m_starve == SMAX);
  endfunction

  function automatic bit m_pend();
    bit p;
    p = ld_valid && (ld_reg == chk_reg);
    foreach (mq[i]) if (mq[i].r == chk_reg) p = 1'b1;
    return rst_n && p;
  endfunction

  // Compare at every falling edge, then advance the model across the next rising edge.
  initial begin
    int   n0;
    bit   acc;
    ent_t le;
    mq.delete();
    m_starve = 0; m_en = 0; m_reg = '0; m_data = '0;
    m_ld_taken = 0; m_pipe_taken = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_en", rf_wr_en, 0);
        chk("rst_reg", rf_wr_reg, 0);
        chk("rst_data", rf_wr_data, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_pend", chk_pending, 0);
        mq.delete();
        m_starve = 0; m_en = 0; m_reg = '0; m_data = '0;
        m_ld_taken = 0; m_pipe_taken = 0;
      end else begin
        chk("rf_wr_en", rf_wr_en, m_en);
        chk("rf_wr_reg", rf_wr_reg, m_reg);
        chk("rf_wr_data", rf_wr_data, m_data);
        chk("ld_ready", ld_ready, m_ready());
        chk("pipe_stall", pipe_stall, m_force());
        chk("chk_pending", chk_pending, m_pend());
        n0 = mq.size();
        acc = ld_valid && (n0 < DEPTH);
        le.r = ld_reg; le.d = ld_data;
        m_ld_taken = acc;
        m_pipe_taken = pipe_wr_en && !m_force();
        if (n0 > 0 && m_starve == SMAX) begin
          m_en = 1; m_reg = mq[0].r; m_data = mq[0].d;
          void'(mq.pop_front());
          if (acc) mq.push_back(le);
          m_starve = 0;
        end else if (pipe_wr_en) begin
          m_en = 1; m_reg = pipe_wr_reg; m_data = pipe_wr_data;
          if (acc) mq.push_back(le);
          m_starve = (n0 == 0) ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
        end else if (n0 > 0) begin
          m_en = 1; m_reg = mq[0].r; m_data = mq[0].d;
          void'(mq.pop_front());
          if (acc) mq.push_back(le);
          m_starve = 0;
        end else if (ld_valid) begin
          m_en = 1; m_reg = ld_reg; m_data = ld_data;
          m_starve = 0;
        end else begin
          m_en = 0;
          m_starve = 0;
        end
      end
    end
  end

  task automatic drive(input logic pwe, input logic [RW-1:0] preg, input logic [DW-1:0] pd,
                       input logic lv, input logic [RW-1:0] lr, input logic [DW-1:0] ldv,
                       input logic [RW-1:0] cr);
    @(posedge clk);
    #1;
    pipe_wr_en = pwe; pipe_wr_reg = preg; pipe_wr_data = pd;
    ld_valid = lv; ld_reg = lr; ld_data = ldv; chk_reg = cr;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [RW-1:0] cr);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, cr);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    pipe_wr_en = 1'b0; pipe_wr_reg = '0; pipe_wr_data = '0;
    ld_valid = 1'b0; ld_reg = '0; ld_data = '0; chk_reg = '0;
    #1;
    chk("lit_rst_en", rf_wr_en, 0);
    chk("lit_rst_ready", ld_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset
    repeat (5) idle(3'd0);
    chk("lit_idle_ready", ld_ready, 1);
    chk("lit_idle_en", rf_wr_en, 0);
    chk("lit_idle_stall", pipe_stall, 0);
    chk("lit_idle_pend", chk_pending, 0);

    // Bypass
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hBEEF, 3'd3);
    chk("lit_byp_pend", chk_pending, 1);
    idle(3'd3);
    chk("lit_byp_en", rf_wr_en, 1);
    chk("lit_byp_reg", rf_wr_reg, 3);
    chk("lit_byp_data", rf_wr_data, 16'hBEEF);
    chk("lit_byp_nobuf", chk_pending, 0);

    // Conflict: pipe first, load next
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 3'd2);
    idle(3'd2);
    chk("lit_cf_data1", rf_wr_data, 16'h1111);
    chk("lit_cf_pend1", chk_pending, 1);
    idle(3'd2);
    chk("lit_cf_reg2", rf_wr_reg, 2);
    chk("lit_cf_data2", rf_wr_data, 16'h2222);
    chk("lit_cf_pend0", chk_pending, 0);
    idle(3'd2);
    chk("lit_cf_none", rf_wr_en, 0);

    // Full buffer, order preserved
    drive(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0A02, 3'd4);
    drive(1'b1, 3'd1, 16'h0102, 1'b1, 3'd3, 16'h0B03, 3'd4);
    drive(1'b1, 3'd1, 16'h0103, 1'b1, 3'd4, 16'h0C04, 3'd4);
    chk("lit_full_rdy3", ld_ready, 0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h0C04, 3'd4);
    chk("lit_full_rdy4", ld_ready, 0);
    chk("lit_full_p3", rf_wr_data, 16'h0103);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h0C04, 3'd4);
    chk("lit_full_rdy5", ld_ready, 1);
    chk("lit_full_a", rf_wr_data, 16'h0A02);
    idle(3'd4);
    chk("lit_full_b", rf_wr_data, 16'h0B03);
    idle(3'd4);
    chk("lit_full_c_reg", rf_wr_reg, 4);
    chk("lit_full_c", rf_wr_data, 16'h0C04);

    // Starvation
    drive(1'b1, 3'd6, 16'h0601, 1'b1, 3'd5, 16'h0A0A, 3'd5);
    for (int k = 2; k <= 5; k++) begin
      drive(1'b1, 3'd6, 16'h0600 + 16'(k), 1'b0, 3'd0, 16'h0, 3'd5);
      chk("lit_sv_nostall", pipe_stall, 0);
    end
    drive(1'b1, 3'd6, 16'h0606, 1'b0, 3'd0, 16'h0, 3'd5);
    chk("lit_sv_stall", pipe_stall, 1);
    chk("lit_sv_p5", rf_wr_data, 16'h0605);
    drive(1'b1, 3'd6, 16'h0606, 1'b0, 3'd0, 16'h0, 3'd5);
    chk("lit_sv_stall0", pipe_stall, 0);
    chk("lit_sv_reg5", rf_wr_reg, 5);
    chk("lit_sv_data5", rf_wr_data, 16'h0A0A);
    idle(3'd5);
    chk("lit_sv_held", rf_wr_data, 16'h0606);

    // Reset mid-operation with two buffered loads
    drive(1'b1, 3'd1, 16'h0111, 1'b1, 3'd2, 16'h0222, 3'd2);
    drive(1'b1, 3'd1, 16'h0112, 1'b1, 3'd3, 16'h0333, 3'd2);
    idle(3'd2);
    chk("lit_mr_en", rf_wr_en, 1);
    chk("lit_mr_pend", chk_pending, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("lit_mr_rst_en", rf_wr_en, 0);
    chk("lit_mr_rst_data", rf_wr_data, 0);
    chk("lit_mr_rst_rdy", ld_ready, 0);
    chk("lit_mr_rst_pend", chk_pending, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3'd2);
    idle(3'd2);
    chk("lit_mr_nostale", rf_wr_en, 0);
    chk("lit_mr_rdy", ld_ready, 1);
    chk("lit_mr_drop", chk_pending, 0);

    // Mixed traffic obeying the hold rules
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (!(ld_valid && !m_ld_taken)) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_reg   = 3'($urandom_range(0, 7));
        ld_data  = 16'($urandom);
      end
      if (!(pipe_wr_en && !m_pipe_taken)) begin
        pipe_wr_en   = ($urandom_range(0, 3) != 0);
        pipe_wr_reg  = 3'($urandom_range(0, 7));
        pipe_wr_data = 16'($urandom);
      end
      chk_reg = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    // Drain with loads released only after acceptance
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (m_ld_taken || !ld_valid) ld_valid = 1'b0;
      pipe_wr_en = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Owns the single register-file write port fed by the write-back stage. Shares that port between two requesters: the in-order pipeline write-back (always-ready) and the variable-latency load-return path from data memory. Late load returns are buffered, the port is granted each cycle, and the pipeline is stalled only to prevent starvation. It also exposes a pending-destination check for the hazard unit.

Parameters:
DATA_W, 16, register data width
REG_W, 3, register index width
DEPTH, 2, load-return buffer entries (power of 2, >=2)
STARVE_MAX, 4, consecutive pipeline grants tolerated while buffer non-empty

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pipe_wr_en  in  1  pipeline WB requests a write this cycle
pipe_wr_reg  in  REG_W  pipeline destination
pipe_wr_data  in  DATA_W  pipeline write data (ALU/mem mux output)
pipe_stall  out  1  pipeline WB must hold and re-present its request next cycle
ld_valid  in  1  load-return offers a write
ld_ready  out  1  arbiter accepts load-return this cycle
ld_reg  in  REG_W  load destination
ld_data  in  DATA_W  load data
rf_wr_en  out  1  register-file write enable (registered)
rf_wr_reg  out  REG_W  register-file write index (registered)
rf_wr_data  out  DATA_W  register-file write data (registered)
chk_reg  in  REG_W  hazard-unit query index
chk_pending  out  1  chk_reg has an outstanding load write

Behaviour:
- Reset (rst_n low, takes effect immediately): rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, buffer emptied (contents dropped), starve counter=0, pipe_stall=0, ld_ready=0, chk_pending=0. After release, ld_ready=1 from the first cycle.
- Load transfer happens when ld_valid && ld_ready. ld_ready = (count < DEPTH). It does not account for a same-cycle pop. When ld_ready=0 the load unit holds its ld_* unchanged.
- Grant priority, evaluated combinationally each cycle:
  1. FORCE: count>0 && starve==STARVE_MAX. Buffer head wins. pipe_stall=1.
  2. PIPE: pipe_wr_en. Pipeline wins. An accepted load is pushed to the buffer.
  3. BUF: count>0. Buffer head wins. An accepted load is pushed to the tail.
  4. BYP: count==0 && ld_valid. Load writes directly with no buffer push.
  5. NONE.
- Output latency is 1 cycle: rf_wr_* is loaded on the rising edge from the granted source. rf_wr_en=0 after a NONE cycle, and rf_wr_reg/data hold their old values.
- pipe_stall is combinational and only asserted in FORCE.
- Buffer is FIFO-ordered, and entries never reorder. Push and pop in the same cycle leave count unchanged.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on a PIPE grant while count>0.
  - Clears on any BUF/FORCE grant or whenever count==0.
- chk_pending = any valid buffer entry with reg==chk_reg, OR (ld_valid && ld_reg==chk_reg). It is purely combinational. The hazard unit uses it to prevent a younger pipeline write being overwritten by an older buffered load; the arbiter itself does no WAW checking.
- Simultaneous pipe_wr_en and load bypass opportunity: PIPE wins and the load goes to the buffer. The load is never dropped while ld_ready=1.

Decomposition:
- Shared package wb_arb_pkg:
  - DATA_W, REG_W defaults.
  - Grant enum GNT_NONE/GNT_PIPE/GNT_BUF/GNT_FORCE/GNT_BYP.
  - Typedef wb_req_t {reg, data}.
- One sub-module: wb_pend_fifo. It is a DEPTH-entry wb_req_t FIFO with push/pop, count, head, async active-low reset, and a combinational match(chk_reg) output.
- Grant logic, starve counter and output registers stay in the top level.

Test Plan:
- Reset then idle: no requests for 5 cycles -> rf_wr_en=0, ld_ready=1, chk_pending=0, pipe_stall=0.
- Bypass: ld_valid, ld_reg=3, ld_data=0xBEEF with buffer empty and pipe idle -> next edge rf_wr_en=1, rf_wr_reg=3, rf_wr_data=0xBEEF, count stays 0.
- Conflict: pipe_wr_en, reg=1, data=0x1111 and ld_valid, reg=2, data=0x2222 in the same cycle -> R1 written next cycle, R2 the cycle after. chk_reg=2 reads chk_pending=1 until the pop.
- Full buffer: pipe_wr_en held high, 3 loads offered back-to-back -> ld_ready low after 2 accepts, third load held and accepted after the first drain, order preserved.
- Starvation: buffer holds R5=0x0A0A, pipe_wr_en high continuously -> after 4 PIPE grants, cycle 5 asserts pipe_stall=1 and writes R5=0x0A0A. The held pipe write lands the next cycle.
- Reset mid-operation: rst_n low with 2 entries buffered and rf_wr_en=1 -> outputs cleared immediately, count=0, no stale write after release.
